// File: rtl/event_tx_arbiter.sv
// EVG transmit slot arbiter: strict priority for requester 0, round-robin
// for the rest, enforced idle gap after events and periodic K28.5 commas.
module event_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int MIN_GAP        = 1,
    parameter int COMMA_INTERVAL = 256
) (
    input  logic              evgTxClk,
    input  logic              evgTxRst_n,
    input  logic              enable,
    input  logic [NREQ-1:0]   reqValid,
    input  logic [8*NREQ-1:0] reqCode,
    output logic [NREQ-1:0]   reqReady,
    output logic [7:0]        txCode,
    output logic              txCharIsK,
    output logic [31:0]       eventCount
);

    localparam int CW = $clog2(COMMA_INTERVAL);
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_INTERVAL - 1);
    localparam logic [3:0]    GAP_LOAD   = 4'(MIN_GAP);
    localparam logic [PW-1:0] RR_FIRST   = PW'(1);
    localparam logic [PW-1:0] RR_LAST    = PW'(NREQ - 1);
    localparam logic [7:0]    K28_5      = 8'hBC;

    logic [CW-1:0]   comma_cnt;
    logic [3:0]      gap_cnt;
    logic [PW-1:0]   rr_ptr;
    logic            comma_slot;
    logic            grant_ok;
    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [7:0]      grant_code;
    logic [PW-1:0]   rr_next;
    logic            event_fire;

    assign comma_slot = (comma_cnt == COMMA_LAST);
    assign grant_ok   = enable && !comma_slot && (gap_cnt == 4'd0);
    assign event_fire = grant_any && (grant_code != 8'd0);
    assign rr_next    = (grant_idx == RR_LAST) ? RR_FIRST
                                               : grant_idx + 1'b1;

    // Grants are withheld while reset is asserted, whatever the state says.
    assign reqReady = grant_oh & {NREQ{evgTxRst_n}};

    // Requester 0 wins outright; others are scanned from rr_ptr upward,
    // first the indices at or above the pointer, then the ones below it.
    always_comb begin
        grant_oh   = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_code = 8'd0;
        if (grant_ok) begin
            if (reqValid[0]) begin
                grant_oh[0] = 1'b1;
                grant_any   = 1'b1;
                grant_code  = reqCode[7:0];
            end else begin
                for (int j = 1; j < NREQ; j++) begin
                    if (!grant_any && reqValid[j] && (PW'(j) >= rr_ptr)) begin
                        grant_oh[j] = 1'b1;
                        grant_any   = 1'b1;
                        grant_idx   = PW'(j);
                        grant_code  = reqCode[8*j +: 8];
                    end
                end
                for (int j = 1; j < NREQ; j++) begin
                    if (!grant_any && reqValid[j] && (PW'(j) < rr_ptr)) begin
                        grant_oh[j] = 1'b1;
                        grant_any   = 1'b1;
                        grant_idx   = PW'(j);
                        grant_code  = reqCode[8*j +: 8];
                    end
                end
            end
        end
    end

    // Free-running comma slot counter.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n)
            comma_cnt <= '0;
        else if (comma_slot)
            comma_cnt <= '0;
        else
            comma_cnt <= comma_cnt + 1'b1;
    end

    // Idle gap: loaded by a nonzero event, otherwise counts down to zero.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n)
            gap_cnt <= 4'd0;
        else if (event_fire)
            gap_cnt <= GAP_LOAD;
        else if (gap_cnt != 4'd0)
            gap_cnt <= gap_cnt - 4'd1;
    end

    // Round-robin pointer moves past a granted requester other than 0.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n)
            rr_ptr <= RR_FIRST;
        else if (grant_any && (grant_idx != '0))
            rr_ptr <= rr_next;
    end

    // Output byte register: comma beats any grant, else granted code or idle.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            txCode    <= 8'd0;
            txCharIsK <= 1'b0;
        end else if (comma_slot) begin
            txCode    <= K28_5;
            txCharIsK <= 1'b1;
        end else if (grant_any) begin
            txCode    <= grant_code;
            txCharIsK <= 1'b0;
        end else begin
            txCode    <= 8'd0;
            txCharIsK <= 1'b0;
        end
    end

    // Count of nonzero events emitted, wrapping naturally.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n)
            eventCount <= 32'd0;
        else if (event_fire)
            eventCount <= eventCount + 32'd1;
    end

endmodule

// File: tb/tb_event_tx_arbiter.sv
// Randomized bench for event_tx_arbiter against a cycle-level
// behavioural model of the slot sharing rules.
module tb_event_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MIN_GAP = 2;
    localparam int CI = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_code = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_code;
    logic              tx_k;
    logic [31:0]       event_count;

    event_tx_arbiter #(
        .NREQ(NREQ),
        .MIN_GAP(MIN_GAP),
        .COMMA_INTERVAL(CI)
    ) dut (
        .evgTxClk(clk),
        .evgTxRst_n(rst_n),
        .enable(enable),
        .reqValid(req_valid),
        .reqCode(req_code),
        .reqReady(req_ready),
        .txCode(tx_code),
        .txCharIsK(tx_k),
        .eventCount(event_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester side state
    bit         pending [NREQ];
    logic [7:0] code [NREQ];
    int         p_new = 50;
    int         p_en = 100;
    bit         no_req0 = 0;

    // Reference model state
    int          cyc;
    int          next_ok;
    int          rr;
    int          last_g;
    logic [7:0]  exp_code;
    logic        exp_k;
    logic [31:0] exp_cnt;
    int          n_comma = 0;

    function automatic logic [7:0] rand_code();
        if ($urandom_range(7) == 0)
            return 8'h00;
        return 8'($urandom_range(255, 1));
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pending[i];
            req_code[8*i +: 8] = code[i];
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        next_ok = 0;
        rr = 1;
        last_g = -1;
        exp_code = 8'h00;
        exp_k = 1'b0;
        exp_cnt = 32'd0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready;
        check("txCode", 32'(tx_code), 32'(exp_code));
        check("txCharIsK", 32'(tx_k), 32'(exp_k));
        check("eventCount", event_count, exp_cnt);
        if (last_g >= 0)
            pending[last_g] = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && !(i == 0 && no_req0)
                && $urandom_range(99) < p_new) begin
                pending[i] = 1;
                code[i] = rand_code();
            end
        end
        enable = ($urandom_range(99) < p_en);
        drive();
        #1;
        g = -1;
        if (enable && (cyc % CI) != CI - 1 && cyc >= next_ok) begin
            if (pending[0]) begin
                g = 0;
            end else begin
                for (int j = rr; j < NREQ; j++)
                    if (g < 0 && pending[j]) g = j;
                for (int j = 1; j < rr; j++)
                    if (g < 0 && pending[j]) g = j;
            end
        end
        exp_ready = '0;
        if (g >= 0)
            exp_ready[g] = 1'b1;
        check("reqReady", 32'(req_ready), 32'(exp_ready));
        if ((cyc % CI) == CI - 1) begin
            exp_code = 8'hBC;
            exp_k = 1'b1;
            n_comma++;
        end else if (g >= 0) begin
            exp_code = code[g];
            exp_k = 1'b0;
        end else begin
            exp_code = 8'h00;
            exp_k = 1'b0;
        end
        if (g >= 0 && code[g] != 8'h00) begin
            exp_cnt = exp_cnt + 32'd1;
            next_ok = cyc + MIN_GAP + 1;
        end
        if (g >= 1)
            rr = (g == NREQ - 1) ? 1 : g + 1;
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with every requester pending, then releases.
    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            if (!pending[i]) begin
                pending[i] = 1;
                code[i] = rand_code();
            end
        end
        enable = 1'b1;
        drive();
        rst_n = 1'b0;
        #1;
        check("rst_reqReady", 32'(req_ready), 32'd0);
        check("rst_txCode", 32'(tx_code), 32'd0);
        check("rst_txCharIsK", 32'(tx_k), 32'd0);
        check("rst_eventCount", event_count, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_reqReady", 32'(req_ready), 32'd0);
        check("rst_hold_txCode", 32'(tx_code), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 0;
            code[i] = 8'h00;
        end
        model_reset();
        @(negedge clk);
        do_reset();
        no_req0 = 1;
        p_new = 100;
        p_en = 100;
        repeat (40) step();
        no_req0 = 0;
        p_new = 30;
        repeat (200) step();
        p_en = 0;
        p_new = 100;
        repeat (20) step();
        p_en = 100;
        p_new = 40;
        repeat (100) step();
        p_en = 80;
        p_new = 60;
        repeat (100) step();
        do_reset();
        p_en = 90;
        p_new = 50;
        repeat (150) step();
        check("commas_seen", 32'(n_comma > 50), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
